// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage multiply/divide sequencer with single HI/LO write; MULDIV_DIVZERO_FAST_EN enables zero-divisor shortcut
module muldiv_ctrl #(
  parameter int MUL_LAT     = 2,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_hold,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stallreq,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy,
  output logic        div_err
);
  localparam logic [1:0] IDLE = 2'd0, MUL_WAIT = 2'd1, DIV_WAIT = 2'd2, DONE = 2'd3;
  localparam logic [2:0] OP_MULT = 3'd1, OP_DIV = 3'd3, OP_DIVU = 3'd4;
  logic [1:0]  state;
  logic [6:0]  cnt;
  logic [31:0] opa, opb, hi, lo;
  logic        sgn, is_div, accept, mul_last, div_to, dz_fast;
  // decode the incoming op and the end-of-wait conditions
  always_comb begin
    is_div   = op_code == OP_DIV || op_code == OP_DIVU;
    accept   = state == IDLE && op_valid && !flush && op_code >= OP_MULT && op_code <= OP_DIVU;
    mul_last = state == MUL_WAIT && cnt == 7'(MUL_LAT - 1);
    div_to   = state == DIV_WAIT && !div_ready && cnt == 7'(DIV_TIMEOUT - 1);
`ifdef MULDIV_DIVZERO_FAST_EN
    dz_fast  = accept && is_div && rt_data == 32'd0;
`else
    dz_fast  = 1'b0;
`endif
  end
  assign mul_signed = sgn;
  assign div_signed = sgn;
  assign mul_a      = opa;
  assign mul_b      = opb;
  assign div_opa    = opa;
  assign div_opb    = opb;
  assign div_start  = state == DIV_WAIT && !div_ready && !flush;
  assign div_annul  = state == DIV_WAIT && (flush || div_to);
  assign stallreq   = accept || (!flush && (state == MUL_WAIT || state == DIV_WAIT));
  assign hilo_we    = state == DONE && !ex_hold && !flush;
  assign hi_o       = hi;
  assign lo_o       = lo;
  assign busy       = state != IDLE;
  // sequencer state, operand latch and HI/LO capture; flush drops the op without touching HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      opa     <= '0;
      opb     <= '0;
      sgn     <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      div_err <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      cnt <= (state == MUL_WAIT || state == DIV_WAIT) ? cnt + 7'd1 : '0;
      case (state)
        IDLE:
          if (accept) begin
            opa     <= rs_data;
            opb     <= rt_data;
            sgn     <= op_code == OP_MULT || op_code == OP_DIV;
            div_err <= 1'b0;
            state   <= dz_fast ? DONE : is_div ? DIV_WAIT : MUL_WAIT;
            if (dz_fast) begin
              hi <= rs_data;
              lo <= '1;
            end
          end
        MUL_WAIT:
          if (mul_last) begin
            {hi, lo} <= mul_result;
            state    <= DONE;
          end
        DIV_WAIT:
          if (div_ready) begin
            {hi, lo} <= div_result;
            state    <= DONE;
          end else if (div_to) begin
            hi      <= '0;
            lo      <= '0;
            div_err <= 1'b1;
            state   <= DONE;
          end
        default:
          if (!ex_hold) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and random checks of muldiv_ctrl against an arithmetic reference
module tb_muldiv_ctrl;
  localparam int MUL_LAT = 2, DIV_TIMEOUT = 64;
  logic clk = 0, rst = 1, flush = 0, ex_hold = 0, op_valid = 0;
  logic [2:0] op_code = 0;
  logic [31:0] rs_data = 0, rt_data = 0;
  logic mul_signed, div_start, div_signed, div_annul, div_ready, stallreq, hilo_we, busy, div_err;
  logic [31:0] mul_a, mul_b, div_opa, div_opb, hi_o, lo_o;
  logic [63:0] mul_result, div_result;
  int checks = 0, errors = 0;
  int dcnt = 0, div_delay = 1;
  int stalls, starts, annuls, annul_cyc, wes, we_cyc;
  logic [31:0] whi, wlo;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_hold(ex_hold), .op_valid(op_valid),
    .op_code(op_code), .rs_data(rs_data), .rt_data(rt_data), .mul_signed(mul_signed),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result), .div_start(div_start),
    .div_signed(div_signed), .div_opa(div_opa), .div_opb(div_opb), .div_annul(div_annul),
    .div_ready(div_ready), .div_result(div_result), .stallreq(stallreq), .hilo_we(hilo_we),
    .hi_o(hi_o), .lo_o(lo_o), .busy(busy), .div_err(div_err));

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_result(input logic [2:0] code, input logic [31:0] a, b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (code == 3'd1) return sa * sb;
    if (code == 3'd2) return {32'd0, a} * {32'd0, b};
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (code == 3'd3) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  assign mul_result = ref_result(mul_signed ? 3'd1 : 3'd2, mul_a, mul_b);
  assign div_result = ref_result(div_signed ? 3'd3 : 3'd4, div_opa, div_opb);
  assign div_ready  = busy && dcnt == div_delay;
  always @(posedge clk) dcnt <= (busy && !rst) ? dcnt + (div_start ? 1 : 0) : 0;

  task automatic chk(input string tag, input logic [63:0] got, exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [2:0] code, input logic [31:0] a, b, input int delay, hold, flush_at);
    int held = 0, cyc = 0;
    div_delay = delay;
    op_valid = 1; op_code = code; rs_data = a; rt_data = b;
    stalls = 0; starts = 0; annuls = 0; annul_cyc = -1; wes = 0; we_cyc = -1;
    while (cyc < 200) begin
      flush = (cyc == flush_at);
      #1;
      ex_hold = busy && !stallreq && held < hold;
      if (ex_hold) held++;
      #1;
      stalls += int'(stallreq);
      starts += int'(div_start);
      if (div_annul) begin annuls++; annul_cyc = cyc; end
      if (hilo_we) begin wes++; we_cyc = cyc; whi = hi_o; wlo = lo_o; end
      @(posedge clk); @(negedge clk);
      op_valid = 0; flush = 0; ex_hold = 0; cyc++;
      if (!busy) break;
    end
    chk("op completes within budget", busy, 0);
  endtask

  task automatic expect_run(input string tag, input int e_stall, e_start, e_annul, e_we, e_wcyc, input logic [63:0] e_res);
    chk({tag, " stallreq cycles"}, stalls, e_stall);
    chk({tag, " div_start cycles"}, starts, e_start);
    chk({tag, " div_annul pulses"}, annuls, e_annul);
    chk({tag, " hilo_we count"}, wes, e_we);
    if (e_we != 0) begin
      chk({tag, " hilo_we cycle"}, we_cyc, e_wcyc);
      chk({tag, " hi/lo"}, {whi, wlo}, e_res);
    end
  endtask

  initial begin
    logic [2:0] c;
    logic [31:0] a, b;
    int d, h;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("reset stallreq", stallreq, 0);
    chk("reset busy", busy, 0);
    chk("reset hilo_we", hilo_we, 0);
    chk("reset hi/lo", {hi_o, lo_o}, 0);
    chk("reset div_err", div_err, 0);
    chk("reset div_start/annul", {div_start, div_annul}, 0);
    @(negedge clk);
    op_valid = 1; op_code = 3'd5;
    #1 chk("undefined op no stall", stallreq, 0);
    @(negedge clk);
    op_valid = 0;
    chk("undefined op not accepted", busy, 0);

    run(3'd1, 32'hFFFF_FFFE, 32'd3, 1, 0, -1);
    expect_run("MULT -2*3", MUL_LAT + 1, 0, 0, 1, MUL_LAT + 1, 64'hFFFF_FFFF_FFFF_FFFA);
    run(3'd2, 32'hFFFF_FFFF, 32'd2, 1, 0, -1);
    expect_run("MULTU", MUL_LAT + 1, 0, 0, 1, MUL_LAT + 1, 64'h0000_0001_FFFF_FFFE);
    run(3'd3, -32'sd7, 32'd2, 33, 0, -1);
    expect_run("DIV -7/2", 35, 33, 0, 1, 35, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run(3'd4, 32'd1000, 32'd7, 33, 0, 10);
    expect_run("DIVU flushed", 10, 9, 1, 0, 0, 0);
    chk("hi/lo held after flush", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run(3'd1, 32'd12345, 32'hFFFF_FF00, 1, 0, -1);
    expect_run("MULT after flush", MUL_LAT + 1, 0, 0, 1, MUL_LAT + 1, ref_result(3'd1, 32'd12345, 32'hFFFF_FF00));
    run(3'd2, 32'h1234_5678, 32'h9ABC_DEF0, 1, 3, -1);
    expect_run("MULTU ex_hold 3", MUL_LAT + 1, 0, 0, 1, MUL_LAT + 4, ref_result(3'd2, 32'h1234_5678, 32'h9ABC_DEF0));
    run(3'd4, 32'd50, 32'd5, 100000, 0, -1);
    expect_run("DIVU timeout", DIV_TIMEOUT + 1, DIV_TIMEOUT, 1, 1, DIV_TIMEOUT + 1, 0);
    chk("timeout annul cycle", annul_cyc, DIV_TIMEOUT);
    @(negedge clk);
    chk("div_err sticky", div_err, 1);
    run(3'd4, 32'd50, 32'd5, DIV_TIMEOUT - 1, 0, -1);
    expect_run("DIVU ready at timeout", DIV_TIMEOUT + 1, DIV_TIMEOUT - 1, 0, 1, DIV_TIMEOUT + 1, {32'd0, 32'd10});
    chk("div_err cleared by new op", div_err, 0);
`ifdef MULDIV_DIVZERO_FAST_EN
    run(3'd3, 32'hDEAD_BEEF, 32'd0, 5, 0, -1);
    expect_run("DIV by zero fast", 1, 0, 0, 1, 1, {32'hDEAD_BEEF, 32'hFFFF_FFFF});
`endif
    for (int i = 0; i < 20; i++) begin
      c = 3'($urandom_range(1, 4));
      a = $urandom;
      b = $urandom;
      if (c >= 3'd3 && b == 0) b = 32'd1;
      d = $urandom_range(1, 40);
      h = $urandom_range(0, 3);
      run(c, a, b, d, h, -1);
      if (c <= 3'd2) expect_run($sformatf("rand%0d mul", i), MUL_LAT + 1, 0, 0, 1, MUL_LAT + 1 + h, ref_result(c, a, b));
      else expect_run($sformatf("rand%0d div", i), d + 2, d, 0, 1, d + 2 + h, ref_result(c, a, b));
      chk($sformatf("rand%0d hi/lo held", i), {hi_o, lo_o}, {whi, wlo});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
